cache_wb_assoc: RTL and testbench

//  Parametrised set-associative, write-back, write-allocate cache between the CPU datapath and the block-wide memory bus.

---
 rtl/cache_wb_assoc_pkg.sv | 15 +
 rtl/cache_wb_assoc_way.sv | 69 ++++++
 rtl/cache_wb_assoc.sv | 166 ++++++++++++++++
 tb/tb_cache_wb_assoc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_wb_assoc_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
package cache_wb_assoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WBACK = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  // Vector width that stays legal when a field collapses to zero bits.
  function automatic int unsigned nz_width(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cache_wb_assoc_way.sv
// One cache way: tag/data/valid/dirty storage with combinational lookup at idx.
module cache_wb_assoc_way #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned TAG_W       = 12,
  parameter int unsigned IDX_SW      = 2,
  parameter int unsigned OFF_W       = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [IDX_SW-1:0]                idx,
  input  logic [TAG_W-1:0]                 tag,
  input  logic [OFF_W-1:0]                 off,
  input  logic                             wr_word,
  input  logic [WORD_SIZE-1:0]             wr_data,
  input  logic                             fill,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] fill_block,
  input  logic                             clean,
  output logic                             hit_c,
  output logic                             valid_c,
  output logic                             dirty_c,
  output logic [TAG_W-1:0]                 tag_c,
  output logic [WORD_SIZE-1:0]             word_c,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] block_c
);

  logic [NUM_SETS-1:0]  valid;
  logic [NUM_SETS-1:0]  dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
  logic [WORD_SIZE-1:0] data_mem [NUM_SETS][BLOCK_WORDS];

  // Status bits need reset; the arrays are qualified by valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (clean) begin
      dirty[idx] <= 1'b0;
    end else if (wr_word) begin
      dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx] <= tag;
      for (int w = 0; w < BLOCK_WORDS; w++)
        data_mem[idx][w] <= fill_block[w*WORD_SIZE +: WORD_SIZE];
    end else if (wr_word) begin
      data_mem[idx][off] <= wr_data;
    end
  end

  always_comb begin
    valid_c = valid[idx];
    dirty_c = dirty[idx];
    tag_c   = tag_mem[idx];
    hit_c   = valid[idx] && (tag_mem[idx] == tag);
    word_c  = data_mem[idx][off];
    block_c = '0;
    for (int w = 0; w < BLOCK_WORDS; w++)
      block_c[w*WORD_SIZE +: WORD_SIZE] = data_mem[idx][w];
  end

endmodule

// File: rtl/cache_wb_assoc.sv
// Set-associative write-back/write-allocate cache: FSM, LRU victim choice,
// memory-bus tri-states and performance counters.
module cache_wb_assoc
  import cache_wb_assoc_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned NUM_WAYS    = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             readC,
  input  logic                             writeC,
  input  logic [WORD_SIZE-1:0]             address,
  inout  wire  [WORD_SIZE-1:0]             data,
  input  logic                             bus_granted,
  input  logic                             input_readyM,
  input  logic                             doneM,
  inout  wire  [BLOCK_WORDS*WORD_SIZE-1:0] dataM,
  output logic [WORD_SIZE-1:0]             addressM,
  output logic                             readM,
  output logic                             writeM,
  output logic                             readyC,
  output logic [WORD_SIZE-1:0]             num_cache_access,
  output logic [WORD_SIZE-1:0]             num_cache_miss,
  output logic [WORD_SIZE-1:0]             num_writeback
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned IDX_SW = nz_width(IDX_W);
  localparam int unsigned TAG_W  = WORD_SIZE - IDX_W - OFF_W;
  localparam int unsigned BLK_W  = BLOCK_WORDS * WORD_SIZE;

  state_e              state, state_n;
  logic [OFF_W-1:0]    req_off;
  logic [IDX_SW-1:0]   req_idx, lat_idx, look_idx;
  logic [TAG_W-1:0]    req_tag, vic_tag;
  logic                vic_way, vic_sel, hit_way;
  logic [NUM_SETS-1:0] lru;

  logic [NUM_WAYS-1:0]  hit_w, valid_w, dirty_w;
  logic [TAG_W-1:0]     tag_w   [NUM_WAYS];
  logic [WORD_SIZE-1:0] word_w  [NUM_WAYS];
  logic [BLK_W-1:0]     block_w [NUM_WAYS];

  logic                 req, hit, miss_go, wr_en, fill_en, clean_en, sel_dirty;
  logic [TAG_W-1:0]     sel_tag;
  logic [WORD_SIZE-1:0] hit_word, addr_m;
  logic [BLK_W-1:0]     vic_block;

  function automatic logic [WORD_SIZE-1:0] make_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_SW-1:0] i);
    return (WORD_SIZE'(t) << (IDX_W + OFF_W)) | (WORD_SIZE'(i) << OFF_W);
  endfunction

  // Index is extracted by mask so a single-set cache needs no zero-width slice.
  assign req_off  = OFF_W'(address);
  assign req_idx  = IDX_SW'((address >> OFF_W) & WORD_SIZE'(NUM_SETS - 1));
  assign req_tag  = TAG_W'(address >> (OFF_W + IDX_W));
  assign look_idx = (state == ST_IDLE) ? req_idx : lat_idx;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_wb_assoc_way #(
      .WORD_SIZE(WORD_SIZE), .BLOCK_WORDS(BLOCK_WORDS), .NUM_SETS(NUM_SETS),
      .TAG_W(TAG_W), .IDX_SW(IDX_SW), .OFF_W(OFF_W)
    ) u_way (
      .clk       (clk),
      .reset_n   (reset_n),
      .idx       (look_idx),
      .tag       (req_tag),
      .off       (req_off),
      .wr_word   (wr_en && (hit_way == 1'(g))),
      .wr_data   (data),
      .fill      (fill_en && (vic_way == 1'(g))),
      .fill_block(dataM),
      .clean     (clean_en && (vic_way == 1'(g))),
      .hit_c     (hit_w[g]),
      .valid_c   (valid_w[g]),
      .dirty_c   (dirty_w[g]),
      .tag_c     (tag_w[g]),
      .word_c    (word_w[g]),
      .block_c   (block_w[g])
    );
  end

  // Hit selection and victim choice: lowest invalid way wins over LRU.
  always_comb begin
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_w[w]) begin
        hit_way  = 1'(w);
        hit_word = word_w[w];
      end
    end
    vic_sel = (NUM_WAYS > 1) ? lru[req_idx] : 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_w[w]) vic_sel = 1'(w);
    sel_dirty = 1'b0;
    sel_tag   = '0;
    vic_block = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (vic_sel == 1'(w)) begin
        sel_dirty = valid_w[w] && dirty_w[w];
        sel_tag   = tag_w[w];
      end
      if (vic_way == 1'(w)) vic_block = block_w[w];
    end
  end

  assign req      = readC || writeC;
  assign hit      = |hit_w;
  assign readyC   = (state == ST_IDLE) && req && hit;
  assign wr_en    = readyC && !readC;
  assign miss_go  = (state == ST_IDLE) && req && !hit && !bus_granted;
  assign fill_en  = (state == ST_FILL) && input_readyM && !bus_granted;
  assign clean_en = (state == ST_WBACK) && doneM && !bus_granted;
  assign readM    = (state == ST_FILL) && !input_readyM && !bus_granted;
  assign writeM   = (state == ST_WBACK) && !doneM && !bus_granted;

  always_comb begin
    addr_m = make_addr(req_tag, lat_idx);
    if (state == ST_WBACK) addr_m = make_addr(vic_tag, lat_idx);
  end

  assign data     = (readC && readyC) ? hit_word : 'z;
  assign dataM    = writeM ? vic_block : 'z;
  assign addressM = (!bus_granted && (state != ST_IDLE)) ? addr_m : 'z;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (miss_go)  state_n = sel_dirty ? ST_WBACK : ST_FILL;
      ST_WBACK: if (clean_en) state_n = ST_FILL;
      ST_FILL:  if (fill_en)  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      vic_way          <= 1'b0;
      vic_tag          <= '0;
      lat_idx          <= '0;
      lru              <= '0;
      num_cache_access <= '0;
      num_cache_miss   <= '0;
      num_writeback    <= '0;
    end else begin
      state <= state_n;
      if (miss_go) begin
        vic_way <= vic_sel;
        vic_tag <= sel_tag;
        lat_idx <= req_idx;
      end
      if ((NUM_WAYS > 1) && readyC) lru[req_idx] <= ~hit_way;
      if (readyC)   num_cache_access <= num_cache_access + WORD_SIZE'(1);
      if (fill_en)  num_cache_miss   <= num_cache_miss + WORD_SIZE'(1);
      if (clean_en) num_writeback    <= num_writeback + WORD_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed bench: default 2-way cache plus a direct-mapped 8x8 instance,
// each held in reset while the other is exercised.
module tb_cache_wb_assoc;

  logic         clk = 1'b0;
  logic         reset_n, sel6;
  logic         readC, writeC, bus_granted;
  logic [15:0]  address, cpu_wd;
  logic         cpu_drive;
  logic         a_irdy = 1'b0, a_done = 1'b0, a_drive = 1'b0;
  logic         man_irdy, man_drive, auto_rd, auto_wr;
  logic [127:0] fill_blk;

  wire  [15:0]  data;
  wire  [63:0]  dataM_a;
  wire  [127:0] dataM_b;
  logic [15:0]  addressM_a, addressM_b;
  logic         readM_a, readM_b, writeM_a, writeM_b, readyC_a, readyC_b;
  logic [15:0]  acc_a, acc_b, miss_a, miss_b, wb_a, wb_b;

  wire          input_readyM = a_irdy | man_irdy;
  wire          doneM        = a_done;
  wire          rst_a        = reset_n && !sel6;
  wire          rst_b        = reset_n && sel6;

  assign data    = cpu_drive ? cpu_wd : 'z;
  assign dataM_a = ((a_drive || man_drive) && !sel6) ? fill_blk[63:0] : 'z;
  assign dataM_b = ((a_drive || man_drive) && sel6) ? fill_blk : 'z;

  wire          readM_s    = sel6 ? readM_b : readM_a;
  wire          writeM_s   = sel6 ? writeM_b : writeM_a;
  wire          readyC_s   = sel6 ? readyC_b : readyC_a;
  wire  [15:0]  addressM_s = sel6 ? addressM_b : addressM_a;
  wire  [15:0]  acc_s      = sel6 ? acc_b : acc_a;
  wire  [15:0]  miss_s     = sel6 ? miss_b : miss_a;
  wire  [15:0]  wb_s       = sel6 ? wb_b : wb_a;
  wire  [127:0] dm_s       = sel6 ? dataM_b : {64'b0, dataM_a};

  cache_wb_assoc #(.WORD_SIZE(16), .BLOCK_WORDS(4), .NUM_SETS(4), .NUM_WAYS(2)) u_dut (
    .clk(clk), .reset_n(rst_a), .readC(readC), .writeC(writeC), .address(address),
    .data(data), .bus_granted(bus_granted), .input_readyM(input_readyM), .doneM(doneM),
    .dataM(dataM_a), .addressM(addressM_a), .readM(readM_a), .writeM(writeM_a),
    .readyC(readyC_a), .num_cache_access(acc_a), .num_cache_miss(miss_a),
    .num_writeback(wb_a)
  );

  cache_wb_assoc #(.WORD_SIZE(16), .BLOCK_WORDS(8), .NUM_SETS(8), .NUM_WAYS(1)) u_dut6 (
    .clk(clk), .reset_n(rst_b), .readC(readC), .writeC(writeC), .address(address),
    .data(data), .bus_granted(bus_granted), .input_readyM(input_readyM), .doneM(doneM),
    .dataM(dataM_b), .addressM(addressM_b), .readM(readM_b), .writeM(writeM_b),
    .readyC(readyC_b), .num_cache_access(acc_b), .num_cache_miss(miss_b),
    .num_writeback(wb_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_blk(input logic [15:0] base, input int n);
    logic [127:0] b = '0;
    for (int w = 0; w < 8; w++)
      if (w < n) b[w*16 +: 16] = base + 16'(w);
    return b;
  endfunction

  // Memory responder: answers a read or write two cycles after the strobe appears.
  int           rd_reqs = 0, wb_reqs = 0, r_lat = 0, w_lat = 0;
  logic         r_act = 1'b0, w_act = 1'b0, r_s, w_s;
  logic [15:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;

  always begin
    @(posedge clk);
    #2;
    r_s = readM_s;
    w_s = writeM_s;
    a_irdy  = 1'b0;
    a_done  = 1'b0;
    a_drive = 1'b0;
    if (auto_rd && r_s) begin
      if (!r_act) begin r_act = 1'b1; r_lat = 0; rd_reqs++; end
      r_lat++;
      if (r_lat >= 2) begin a_irdy = 1'b1; a_drive = 1'b1; r_act = 1'b0; end
    end
    if (auto_wr && w_s) begin
      if (!w_act) begin
        w_act = 1'b1; w_lat = 0; wb_reqs++;
        wb_addr = addressM_s;
        wb_data = dm_s;
      end
      w_lat++;
      if (w_lat >= 2) begin a_done = 1'b1; w_act = 1'b0; end
    end
  end

  task automatic cpu_req(input logic rd, input logic [15:0] addr, input logic [15:0] wd,
                         output logic [15:0] rdata, output int waits);
    waits = 0;
    @(negedge clk);
    address = addr; readC = rd; writeC = !rd; cpu_wd = wd; cpu_drive = !rd;
    #1;
    while (!readyC_s && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk("req_timeout", 16'(readyC_s), 16'h1);
    rdata = data;
    @(posedge clk);
    #1;
    readC = 1'b0; writeC = 1'b0; cpu_drive = 1'b0;
  endtask

  logic [15:0] rd;
  int          wt, n0;

  initial begin
    reset_n = 1'b0; sel6 = 1'b0; readC = 1'b0; writeC = 1'b0; address = '0;
    cpu_wd = '0; cpu_drive = 1'b0; bus_granted = 1'b0; man_irdy = 1'b0;
    man_drive = 1'b0; auto_rd = 1'b1; auto_wr = 1'b1; fill_blk = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_readM", 16'(readM_s), 16'h0);
    chk("rst_writeM", 16'(writeM_s), 16'h0);
    chk("rst_readyC", 16'(readyC_s), 16'h0);
    chk("rst_access", acc_s, 16'h0);
    chk("rst_miss", miss_s, 16'h0);
    chk("rst_wb", wb_s, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // T1 cold read miss
    fill_blk = mk_blk(16'h0001, 4);
    cpu_req(1'b1, 16'h0010, 16'h0, rd, wt);
    chk("t1_data", rd, 16'h0001);
    chk("t1_readM_count", 16'(rd_reqs), 16'd1);
    chk("t1_miss", miss_s, 16'd1);
    chk("t1_access", acc_s, 16'd1);

    // T2 read hit in same block
    cpu_req(1'b1, 16'h0011, 16'h0, rd, wt);
    chk("t2_data", rd, 16'h0002);
    chk("t2_same_cycle", 16'(wt), 16'd0);
    chk("t2_no_readM", 16'(rd_reqs), 16'd1);
    chk("t2_access", acc_s, 16'd2);
    chk("t2_miss", miss_s, 16'd1);

    // T3 write hit, second way fill, dirty eviction
    cpu_req(1'b0, 16'h0012, 16'hBEEF, rd, wt);
    chk("t3_wr_same_cycle", 16'(wt), 16'd0);
    fill_blk = mk_blk(16'h0050, 4);
    cpu_req(1'b1, 16'h0052, 16'h0, rd, wt);
    chk("t3_data52", rd, 16'h0052);
    chk("t3_no_wb_yet", 16'(wb_reqs), 16'd0);
    fill_blk = mk_blk(16'h0090, 4);
    cpu_req(1'b1, 16'h0092, 16'h0, rd, wt);
    chk("t3_data92", rd, 16'h0092);
    chk("t3_wb_reqs", 16'(wb_reqs), 16'd1);
    chk("t3_wb_addr", wb_addr, 16'h0010);
    chkb("t3_wb_data", wb_data, {64'h0, 64'h0004_BEEF_0002_0001});
    chk("t3_writeback", wb_s, 16'd1);
    chk("t3_miss", miss_s, 16'd3);
    chk("t3_access", acc_s, 16'd5);
    cpu_req(1'b1, 16'h0052, 16'h0, rd, wt);
    chk("t3_way1_kept", rd, 16'h0052);
    chk("t3_way1_hit", 16'(wt), 16'd0);

    // T4 bus grant during FILL, with an ignored memory strobe
    auto_rd = 1'b0;
    fill_blk = mk_blk(16'h0100, 4);
    @(negedge clk);
    address = 16'h0104; readC = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_readM_pre", 16'(readM_s), 16'h1);
    chk("t4_addressM", addressM_s, 16'h0104);
    bus_granted = 1'b1;
    #1;
    chk("t4_readM_granted", 16'(readM_s), 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      man_irdy = (i == 1); man_drive = (i == 1);
      #1;
      chk("t4_readM_hold", 16'(readM_s), 16'h0);
    end
    @(negedge clk);
    man_irdy = 1'b0; man_drive = 1'b0; bus_granted = 1'b0;
    #1;
    chk("t4_readM_resume", 16'(readM_s), 16'h1);
    chk("t4_no_ready", 16'(readyC_s), 16'h0);
    chk("t4_miss_unchanged", miss_s, 16'd3);
    @(negedge clk);
    man_irdy = 1'b1; man_drive = 1'b1;
    @(negedge clk);
    man_irdy = 1'b0; man_drive = 1'b0;
    #1;
    chk("t4_readyC", 16'(readyC_s), 16'h1);
    chk("t4_data", data, 16'h0100);
    @(posedge clk);
    #1;
    readC = 1'b0;
    chk("t4_miss", miss_s, 16'd4);
    chk("t4_access", acc_s, 16'd7);
    auto_rd = 1'b1;
    bus_granted = 1'b1;
    cpu_req(1'b1, 16'h0092, 16'h0, rd, wt);
    chk("t4_hit_granted", rd, 16'h0092);
    chk("t4_hit_granted_lat", 16'(wt), 16'd0);
    bus_granted = 1'b0;

    // T5 reset during writeback
    fill_blk = mk_blk(16'h0200, 4);
    cpu_req(1'b0, 16'h0208, 16'h1234, rd, wt);
    fill_blk = mk_blk(16'h0300, 4);
    cpu_req(1'b1, 16'h0308, 16'h0, rd, wt);
    chk("t5_data308", rd, 16'h0300);
    chk("t5_access_pre", acc_s, 16'd10);
    auto_wr = 1'b0;
    @(negedge clk);
    address = 16'h0408; readC = 1'b1;
    #1;
    wt = 0;
    while (!writeM_s && wt < 20) begin
      @(negedge clk);
      #1;
      wt++;
    end
    chk("t5_writeM", 16'(writeM_s), 16'h1);
    chk("t5_wb_addr", addressM_s, 16'h0208);
    chkb("t5_wb_data", dm_s, {64'h0, 64'h0203_0202_0201_1234});
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_writeM", 16'(writeM_s), 16'h0);
    chk("t5_rst_readM", 16'(readM_s), 16'h0);
    chk("t5_rst_readyC", 16'(readyC_s), 16'h0);
    chk("t5_rst_access", acc_s, 16'h0);
    chk("t5_rst_miss", miss_s, 16'h0);
    chk("t5_rst_wb", wb_s, 16'h0);
    readC = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    auto_wr = 1'b1;
    n0 = rd_reqs;
    fill_blk = mk_blk(16'h0400, 4);
    cpu_req(1'b1, 16'h0408, 16'h0, rd, wt);
    chk("t5_post_data", rd, 16'h0400);
    chk("t5_post_readM", 16'(rd_reqs - n0), 16'd1);
    chk("t5_post_miss", miss_s, 16'd1);
    chk("t5_post_access", acc_s, 16'd1);

    // T6 direct-mapped 8 sets x 8 words
    @(negedge clk);
    reset_n = 1'b0; sel6 = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_access", acc_s, 16'h0);
    chk("t6_rst_readyC", 16'(readyC_s), 16'h0);
    reset_n = 1'b1;
    n0 = wb_reqs;
    fill_blk = mk_blk(16'h0001, 8);
    cpu_req(1'b1, 16'h0040, 16'h0, rd, wt);
    chk("t6_t1_data", rd, 16'h0001);
    cpu_req(1'b1, 16'h0041, 16'h0, rd, wt);
    chk("t6_t2_data", rd, 16'h0002);
    chk("t6_t2_lat", 16'(wt), 16'd0);
    cpu_req(1'b0, 16'h0042, 16'hBEEF, rd, wt);
    fill_blk = mk_blk(16'h0080, 8);
    cpu_req(1'b1, 16'h0082, 16'h0, rd, wt);
    chk("t6_data82", rd, 16'h0082);
    chk("t6_wb_addr", wb_addr, 16'h0040);
    chkb("t6_wb_data", wb_data, 128'h0008_0007_0006_0005_0004_BEEF_0002_0001);
    fill_blk = mk_blk(16'h00C0, 8);
    cpu_req(1'b1, 16'h00C2, 16'h0, rd, wt);
    chk("t6_dataC2", rd, 16'h00C2);
    chk("t6_wb_reqs", 16'(wb_reqs - n0), 16'd1);
    chk("t6_access", acc_s, 16'd5);
    chk("t6_miss", miss_s, 16'd3);
    chk("t6_writeback", wb_s, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
